axi3_line_refill: RTL and testbench
===================================

// Module: axi3_line_refill
// PURPOSE
// - Parametrised AXI3 burst read master. Fetches one cache line of LINE_WIDTH bits per request.
// - Drives the master side of axi3_rd_if; sits between an I$/D$ miss handler and the AXI3 read crossbar.
// - Accepts a refill request, issues one AR burst, and assembles the R beats into a line buffer.
// - Returns the full line plus a sticky error flag. Single outstanding transaction.
// PARAMETERS
// - LINE_WIDTH  256  line size in bits; LINE_WORDS=LINE_WIDTH/32, legal 2..16 (power of 2); OFS=log2(LINE_WIDTH/8)
// - BUS_WIDTH   4    AXI ID width, passed to axi3_rd_if
// - ARID        0    ID driven on arid; expected on rid
// PORTS
// - clk             in   1           clock
// - rst             in   1           reset, synchronous, active-high
// - req_valid       in   1           refill request
// - req_addr        in   32          physical miss address (phys_t)
// - req_ready       out  1           request accepted when req_valid&req_ready
// - resp_valid      out  1           one-cycle pulse: line complete
// - resp_line       out  LINE_WIDTH  assembled line; word i at [32*i+31:32*i]
// - resp_err        out  1           valid with resp_valid: any bus/protocol error
// - resp_crit_valid out  1           first-beat pulse (AXI3_RD_WRAP_EN only, else 0)
// - resp_crit_word  out  32          first-beat data (AXI3_RD_WRAP_EN only, else 0)
// - axi             mp   -           axi3_rd_if.master (axi3_rd_req, arid / axi3_rd_resp, rid)
// BEHAVIOUR
// - Reset outputs: FSM=IDLE; req_ready=0 while rst; arvalid=0; rready=0; resp_valid=0; resp_err=0; line buffer=0; crit=0.
// - FSM IDLE -> ADDR -> DATA -> DONE -> IDLE.
// - IDLE: req_ready=1. On handshake, latch addr, clear err, clear beat counter; -> ADDR.
// - ADDR: arvalid=1. araddr/arlen/etc. held stable until arready. On arvalid&arready -> DATA. rready=0.
// - AR fields: arlen=LINE_WORDS-1, arsize=3'b010, arlock=0, arcache=0, arprot=0, arid=ARID.
// - DATA: rready=1. Each rvalid beat writes word[ptr]; ptr+1 mod LINE_WORDS; cnt+1.
// - Error: rresp!=0 or rid!=ARID sets err (sticky); the beat is still stored.
// - Last beat = rlast OR cnt==LINE_WORDS-1. If rlast and cnt!=LINE_WORDS-1 (early) -> err. If cnt==LINE_WORDS-1 and !rlast -> err.
// - On the last beat -> DONE. Extra beats after DONE are never accepted: rready=0 outside DATA.
// - DONE: resp_valid=1 for exactly one cycle, no backpressure; -> IDLE. resp_line holds until the next refill's first beat.
// - Latency (zero-wait slave): accept @0, AR @1, beats @2..LINE_WORDS+1, resp_valid @LINE_WORDS+2.
// - rvalid gaps: stall in DATA, no timeout.
// - req_valid outside IDLE: ignored (req_ready=0).
// - rst mid-operation: next cycle FSM=IDLE, all outputs at reset values, partial line discarded. The system resets the slave with the same rst.
// CONFIGURATION
// - AXI3_RD_WRAP_EN defined:
//   - araddr={req_addr[31:2],2'b00}, arburst=2'b10 (WRAP); ptr starts at req_addr[OFS-1:2] (critical word first).
//   - First beat also pulses resp_crit_valid with resp_crit_word=rdata in the same cycle as rvalid&rready.
// - AXI3_RD_WRAP_EN undefined:
//   - araddr={req_addr[31:OFS],OFS'0}, arburst=2'b01 (INCR); ptr starts at 0.
//   - resp_crit_valid/resp_crit_word tied 0. Ports exist in both builds.
// TESTING (LINE_WIDTH=256, ARID=0, WRAP off unless noted)
// - INCR zero-wait:
//   - Stimulus: req 0x1FC0_0014; beats 0xA0..0xA7, rlast on the 8th.
//   - Required: araddr=0x1FC0_0000, arlen=7, arburst=01 @1; resp_valid only @10; resp_line[31:0]=0xA0, [255:224]=0xA7; resp_err=0.
// - AR backpressure:
//   - Stimulus: arready low 3 cycles.
//   - Required: arvalid/araddr stable 4 cycles; req_ready=0; no rready until AR accepted; rvalid gaps of 2 cycles still yield the correct line.
// - Bus error:
//   - Stimulus: rresp=2'b10 on beat 3 (also run rid=1 on beat 6).
//   - Required: all 8 words stored; resp_err=1 with resp_valid.
// - Burst length mismatch:
//   - Stimulus A: rlast on beat 5. Required: DONE after beat 5, resp_err=1.
//   - Stimulus B: no rlast. Required: DONE after beat 8, resp_err=1, rready=0 afterwards.
// - Reset mid-burst:
//   - Stimulus: rst on beat 4; slave reset too; new req 0x0000_0040.
//   - Required: outputs at reset next cycle, no resp_valid for the old request; new AR araddr=0x40; clean line, resp_err=0.
// - AXI3_RD_WRAP_EN:
//   - Stimulus: req 0x0000_0014; beats 0xB0..0xB7.
//   - Required: araddr=0x14, arburst=10; resp_crit_valid with 0xB0 on the first beat; word5=0xB0, word7=0xB2, word0=0xB3, word4=0xB7.

Source files
------------

// File: rtl/axi3_line_refill_if.sv
// axi3_rd_if: AXI3 read-address and read-data channels between one burst master and its slave.
// A transfer happens on every rising edge where valid and ready are both high; the valid side holds its payload stable until then.
interface axi3_rd_if #(
    parameter int unsigned BUS_WIDTH = 4
);
    logic                 arvalid;
    logic                 arready;
    logic [31:0]          araddr;
    logic [BUS_WIDTH-1:0] arid;
    logic [3:0]           arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;
    logic [1:0]           arlock;
    logic [3:0]           arcache;
    logic [2:0]           arprot;
    logic                 rvalid;
    logic                 rready;
    logic [31:0]          rdata;
    logic [BUS_WIDTH-1:0] rid;
    logic [1:0]           rresp;
    logic                 rlast;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, rready,
        input  arready, rvalid, rdata, rid, rresp, rlast
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, rready,
        output arready, rvalid, rdata, rid, rresp, rlast
    );
endinterface

// File: rtl/axi3_line_refill.sv
// axi3_line_refill: single-outstanding AXI3 burst read master that fetches one cache line per request.
// Define AXI3_RD_WRAP_EN for critical-word-first WRAP bursts; the default build issues line-aligned INCR bursts.
module axi3_line_refill #(
    parameter int unsigned          LINE_WIDTH = 256,
    parameter int unsigned          BUS_WIDTH  = 4,
    parameter logic [BUS_WIDTH-1:0] ARID       = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [31:0]           req_addr,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [LINE_WIDTH-1:0] resp_line,
    output logic                  resp_err,
    output logic                  resp_crit_valid,
    output logic [31:0]           resp_crit_word,
    output logic [1:0]            dbg_state,
    axi3_rd_if.master             axi
);
    localparam int unsigned LINE_WORDS = LINE_WIDTH / 32;
    localparam int unsigned OFS        = $clog2(LINE_WIDTH / 8);
    localparam int unsigned PTR_W      = OFS - 2;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic                  err_q, err_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [PTR_W-1:0]      cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;

    logic accept;
    logic beat;
    logic beat_cnt_last;
    logic beat_last;
    logic beat_err;

    assign accept        = (state_q == S_IDLE) && req_valid;
    assign beat          = (state_q == S_DATA) && axi.rvalid;
    assign beat_cnt_last = (cnt_q == LAST_IDX);
    assign beat_last     = axi.rlast || beat_cnt_last;
    // rlast must coincide with the final counted beat; either side arriving alone is a protocol error.
    assign beat_err      = (axi.rresp != 2'b00) || (axi.rid != ARID) || (axi.rlast != beat_cnt_last);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid) state_d = S_ADDR;
            S_ADDR: if (axi.arready) state_d = S_DATA;
            S_DATA: if (axi.rvalid && beat_last) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready   = (state_q == S_IDLE) && !rst;
        resp_valid  = (state_q == S_DONE);
        axi.arvalid = (state_q == S_ADDR);
        axi.rready  = (state_q == S_DATA);
        axi.araddr  = addr_q;
        axi.arid    = ARID;
        axi.arlen   = 4'(LINE_WORDS - 1);
        axi.arsize  = 3'b010;
        axi.arlock  = 2'b00;
        axi.arcache = 4'b0000;
        axi.arprot  = 3'b000;
`ifdef AXI3_RD_WRAP_EN
        axi.arburst     = 2'b10;
        resp_crit_valid = beat && (cnt_q == '0);
        resp_crit_word  = resp_crit_valid ? axi.rdata : 32'h0;
`else
        axi.arburst     = 2'b01;
        resp_crit_valid = 1'b0;
        resp_crit_word  = 32'h0;
`endif
    end

    always_comb begin
        addr_d = addr_q;
        err_d  = err_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        line_d = line_q;
        if (accept) begin
            err_d = 1'b0;
            cnt_d = '0;
`ifdef AXI3_RD_WRAP_EN
            addr_d = req_addr & ~32'h3;
            ptr_d  = req_addr[OFS-1:2];
`else
            addr_d = req_addr & ~32'(LINE_WIDTH / 8 - 1);
            ptr_d  = '0;
`endif
        end
        // Erroneous beats are still stored so the line is as complete as the bus allowed.
        if (beat) begin
            line_d[{ptr_q, 5'b00000} +: 32] = axi.rdata;
            ptr_d = ptr_q + PTR_W'(1);
            cnt_d = cnt_q + PTR_W'(1);
            if (beat_err) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            err_q  <= 1'b0;
            ptr_q  <= '0;
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            addr_q <= addr_d;
            err_q  <= err_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

    assign resp_line = line_q;
    assign resp_err  = err_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_axi3_line_refill.sv
// tb_axi3_line_refill: randomized and directed refills against a slave model and a line-level reference model.
module tb_axi3_line_refill;
    localparam int LW = 8;
`ifdef AXI3_RD_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         req_ready;
    logic         resp_valid;
    logic [255:0] resp_line;
    logic         resp_err;
    logic         resp_crit_valid;
    logic [31:0]  resp_crit_word;
    logic [1:0]   dbg_state;

    axi3_rd_if #(.BUS_WIDTH(4)) axi ();

    axi3_line_refill #(.LINE_WIDTH(256), .BUS_WIDTH(4), .ARID(4'h0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_line(resp_line), .resp_err(resp_err),
        .resp_crit_valid(resp_crit_valid), .resp_crit_word(resp_crit_word),
        .dbg_state(dbg_state), .axi(axi)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Beat stimulus for the slave model
    logic [31:0] bd[16];
    logic [1:0]  br[16];
    logic [3:0]  bi[16];
    logic        bl[16];
    int          nb;

    // Observations collected by the driver
    int           obs_ar_cycle, obs_ar_count, obs_arv_cycles, obs_resp_cycle, obs_resp_count;
    int           obs_beats, obs_crit_count;
    bit           obs_ar_unstable, obs_busy_ready, obs_rready_early, obs_rready_late, obs_req_ready_idle;
    logic [31:0]  obs_araddr, obs_crit_word;
    logic [3:0]   obs_arlen, obs_arcache, obs_arid;
    logic [2:0]   obs_arsize, obs_arprot;
    logic [1:0]   obs_arburst, obs_arlock;
    logic [255:0] obs_line;
    logic         obs_err;

    // Scoreboard: expected line words and error
    logic [31:0] exp_q[$];
    logic [31:0] mdl_line[LW];
    logic        exp_err;
    int          exp_beats;

    task automatic set_beats_seq(input logic [31:0] first, input int n);
        for (int k = 0; k < 16; k++) begin
            bd[k] = first + 32'(k);
            br[k] = 2'b00;
            bi[k] = 4'h0;
            bl[k] = (k == LW - 1);
        end
        nb = n;
    endtask

    function automatic logic [31:0] exp_araddr(input logic [31:0] addr);
        return WRAP ? (addr & ~32'h3) : (addr & ~32'h1F);
    endfunction

    // A line is filled from the start word onward, wrapping; the burst ends at rlast or the 8th beat.
    task automatic model_refill(input logic [31:0] addr);
        int base;
        int term;
        base = WRAP ? int'(addr[4:2]) : 0;
        exp_err = 1'b0;
        term = -1;
        for (int k = 0; k < nb && term < 0; k++) begin
            mdl_line[(base + k) % LW] = bd[k];
            if (br[k] != 2'b00 || bi[k] != 4'h0) exp_err = 1'b1;
            if (bl[k] || k == LW - 1) begin
                term = k;
                if (!(k == LW - 1 && bl[k])) exp_err = 1'b1;
            end
        end
        exp_beats = term + 1;
        exp_q.delete();
        for (int i = 0; i < LW; i++) exp_q.push_back(mdl_line[i]);
    endtask

    task automatic idle_bus();
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = 32'h0;
        axi.rid     = 4'h0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b0;
    endtask

    // Driver: issues one request and plays the slave; rst_beat >= 0 asserts rst together with that beat.
    task automatic do_refill(input logic [31:0] addr, input int ar_delay, input int gap,
                             input bit hold_req, input int rst_beat);
        int b, gcnt, wcnt, post;
        bit ar_done, resp_seen, aborted;
        obs_ar_cycle = -1; obs_ar_count = 0; obs_arv_cycles = 0; obs_resp_cycle = -1;
        obs_resp_count = 0; obs_beats = 0; obs_crit_count = 0; obs_crit_word = 32'h0;
        obs_ar_unstable = 0; obs_busy_ready = 0; obs_rready_early = 0; obs_rready_late = 0;
        obs_line = '0; obs_err = 1'b0;
        b = 0; gcnt = 0; wcnt = 0; post = 0; ar_done = 0; resp_seen = 0; aborted = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        #1 obs_req_ready_idle = req_ready;
        @(posedge clk);
        for (int k = 1; k < 300 && post < 4; k++) begin
            @(negedge clk);
            if (!hold_req) req_valid = 1'b0;
            idle_bus();
            if (axi.arvalid && !ar_done) begin
                axi.arready = (wcnt >= ar_delay);
                wcnt++;
            end
            if (ar_done && b < nb) begin
                if (gcnt > 0) begin
                    gcnt--;
                end else begin
                    axi.rvalid = 1'b1;
                    axi.rdata  = bd[b];
                    axi.rresp  = br[b];
                    axi.rid    = bi[b];
                    axi.rlast  = bl[b];
                end
            end
            if (axi.rvalid && b == rst_beat) begin
                rst = 1'b1;
                aborted = 1;
                break;
            end
            #1;
            if (axi.arvalid) begin
                obs_arv_cycles++;
                if (obs_arv_cycles == 1) begin
                    obs_araddr = axi.araddr; obs_arlen = axi.arlen; obs_arsize = axi.arsize;
                    obs_arburst = axi.arburst; obs_arlock = axi.arlock; obs_arcache = axi.arcache;
                    obs_arprot = axi.arprot; obs_arid = axi.arid;
                end else if (axi.araddr !== obs_araddr || axi.arlen !== obs_arlen || axi.arburst !== obs_arburst) begin
                    obs_ar_unstable = 1;
                end
            end
            if (axi.arvalid && axi.arready) begin
                obs_ar_count++;
                obs_ar_cycle = k;
            end
            if (!resp_seen && req_ready) obs_busy_ready = 1;
            if (!ar_done && axi.rready) obs_rready_early = 1;
            if (resp_seen && axi.rready) obs_rready_late = 1;
            if (resp_crit_valid) begin
                obs_crit_count++;
                obs_crit_word = resp_crit_word;
            end
            if (axi.rvalid && axi.rready) begin
                obs_beats++;
                b++;
                gcnt = gap;
            end
            if (resp_valid) begin
                obs_resp_count++;
                obs_resp_cycle = k;
                obs_line = resp_line;
                obs_err = resp_err;
                resp_seen = 1;
                req_valid = 1'b0;
            end
            if (resp_seen) post++;
            if (axi.arvalid && axi.arready) ar_done = 1;
        end
        if (aborted) @(posedge clk);
        else begin
            @(negedge clk);
            idle_bus();
            req_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = 32'h0;
        idle_bus();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
        checks++; if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0) begin errors++; $display("FAIL reset_axi got arvalid=%b rready=%b want 0 0", axi.arvalid, axi.rready); end
        checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp got valid=%b err=%b want 0 0", resp_valid, resp_err); end
        checks++; if (resp_line !== 256'h0) begin errors++; $display("FAIL reset_line got=%h want=0", resp_line); end
        checks++; if (resp_crit_valid !== 1'b0 || resp_crit_word !== 32'h0) begin errors++; $display("FAIL reset_crit got %b %h want 0 0", resp_crit_valid, resp_crit_word); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
        rst = 1'b0;
        for (int i = 0; i < LW; i++) mdl_line[i] = 32'h0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got=%b want=1", req_ready); end
    endtask

    task automatic test_incr_zero_wait();
        logic [31:0] w;
        set_beats_seq(32'hA0, 8);
        model_refill(32'h1FC0_0014);
        do_refill(32'h1FC0_0014, 0, 0, 1'b0, -1);
        checks++; if (obs_ar_cycle != 1) begin errors++; $display("FAIL zw_ar_cycle got=%0d want=1", obs_ar_cycle); end
        checks++; if (obs_araddr !== exp_araddr(32'h1FC0_0014)) begin errors++; $display("FAIL zw_araddr got=%h want=%h", obs_araddr, exp_araddr(32'h1FC0_0014)); end
        checks++; if (obs_arlen !== 4'd7 || obs_arsize !== 3'b010) begin errors++; $display("FAIL zw_arlen_size got=%0d/%b want=7/010", obs_arlen, obs_arsize); end
        checks++; if (obs_arburst !== (WRAP ? 2'b10 : 2'b01)) begin errors++; $display("FAIL zw_arburst got=%b", obs_arburst); end
        checks++; if (obs_arlock !== 2'b00 || obs_arcache !== 4'h0 || obs_arprot !== 3'b000 || obs_arid !== 4'h0) begin errors++; $display("FAIL zw_ar_attrs got lock=%b cache=%h prot=%b id=%h want all 0", obs_arlock, obs_arcache, obs_arprot, obs_arid); end
        checks++; if (obs_resp_count != 1 || obs_resp_cycle != 10) begin errors++; $display("FAIL zw_resp_timing got count=%0d cycle=%0d want 1 @10", obs_resp_count, obs_resp_cycle); end
        for (int i = 0; i < LW; i++) begin
            w = exp_q.pop_front();
            checks++; if (obs_line[32*i +: 32] !== w) begin errors++; $display("FAIL zw_word%0d got=%h want=%h", i, obs_line[32*i +: 32], w); end
        end
`ifndef AXI3_RD_WRAP_EN
        checks++; if (obs_line[31:0] !== 32'hA0 || obs_line[255:224] !== 32'hA7) begin errors++; $display("FAIL zw_ends got=%h/%h want=a0/a7", obs_line[31:0], obs_line[255:224]); end
`endif
        checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL zw_err got=%b want=%b", obs_err, exp_err); end
        checks++; if (obs_crit_count != (WRAP ? 1 : 0)) begin errors++; $display("FAIL zw_crit_count got=%0d want=%0d", obs_crit_count, WRAP ? 1 : 0); end
    endtask

    task automatic test_ar_backpressure();
        logic [31:0] w;
        set_beats_seq(32'h5500_0010, 8);
        model_refill(32'h0000_1234);
        do_refill(32'h0000_1234, 3, 2, 1'b1, -1);
        checks++; if (obs_arv_cycles != 4 || obs_ar_unstable) begin errors++; $display("FAIL bp_ar_hold got cycles=%0d unstable=%0d want 4 0", obs_arv_cycles, obs_ar_unstable); end
        checks++; if (obs_busy_ready) begin errors++; $display("FAIL bp_req_ready got=1 while busy want=0"); end
        checks++; if (obs_rready_early) begin errors++; $display("FAIL bp_rready_early got=1 want=0"); end
        checks++; if (obs_ar_count != 1 || obs_resp_count != 1) begin errors++; $display("FAIL bp_counts got ar=%0d resp=%0d want 1 1", obs_ar_count, obs_resp_count); end
        for (int i = 0; i < LW; i++) begin
            w = exp_q.pop_front();
            checks++; if (obs_line[32*i +: 32] !== w) begin errors++; $display("FAIL bp_word%0d got=%h want=%h", i, obs_line[32*i +: 32], w); end
        end
        checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL bp_err got=%b want=%b", obs_err, exp_err); end
    endtask

    task automatic test_bus_error();
        logic [31:0] w;
        for (int run = 0; run < 2; run++) begin
            set_beats_seq(32'hD0 + 32'(run * 16), 8);
            if (run == 0) br[2] = 2'b10;
            else          bi[5] = 4'h1;
            model_refill(32'h0000_2000);
            do_refill(32'h0000_2000, 0, 0, 1'b0, -1);
            checks++; if (obs_beats != 8) begin errors++; $display("FAIL berr%0d_beats got=%0d want=8", run, obs_beats); end
            for (int i = 0; i < LW; i++) begin
                w = exp_q.pop_front();
                checks++; if (obs_line[32*i +: 32] !== w) begin errors++; $display("FAIL berr%0d_word%0d got=%h want=%h", run, i, obs_line[32*i +: 32], w); end
            end
            checks++; if (obs_resp_count != 1 || obs_err !== 1'b1) begin errors++; $display("FAIL berr%0d_err got resp=%0d err=%b want 1 1", run, obs_resp_count, obs_err); end
        end
    endtask

    task automatic test_len_mismatch();
        logic [31:0] w;
        // Early rlast on beat 5; the slave keeps offering the rest
        set_beats_seq(32'hC0, 8);
        bl[7] = 1'b0;
        bl[4] = 1'b1;
        model_refill(32'h0000_3000);
        do_refill(32'h0000_3000, 0, 0, 1'b0, -1);
        checks++; if (obs_beats != 5 || obs_resp_cycle != 7) begin errors++; $display("FAIL lenA_done got beats=%0d cycle=%0d want 5 @7", obs_beats, obs_resp_cycle); end
        checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL lenA_err got=%b want=1", obs_err); end
        for (int i = 0; i < LW; i++) begin
            w = exp_q.pop_front();
            checks++; if (obs_line[32*i +: 32] !== w) begin errors++; $display("FAIL lenA_word%0d got=%h want=%h", i, obs_line[32*i +: 32], w); end
        end
        // No rlast at all, with two extra beats on offer
        set_beats_seq(32'hE0, 10);
        bl[7] = 1'b0;
        model_refill(32'h0000_4000);
        do_refill(32'h0000_4000, 0, 0, 1'b0, -1);
        checks++; if (obs_beats != 8 || obs_resp_cycle != 10) begin errors++; $display("FAIL lenB_done got beats=%0d cycle=%0d want 8 @10", obs_beats, obs_resp_cycle); end
        checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL lenB_err got=%b want=1", obs_err); end
        checks++; if (obs_rready_late) begin errors++; $display("FAIL lenB_rready_after got=1 want=0"); end
        for (int i = 0; i < LW; i++) begin
            w = exp_q.pop_front();
            checks++; if (obs_line[32*i +: 32] !== w) begin errors++; $display("FAIL lenB_word%0d got=%h want=%h", i, obs_line[32*i +: 32], w); end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] w;
        int spurious;
        set_beats_seq(32'h7700, 8);
        br[1] = 2'b11;
        do_refill(32'h0000_5000, 0, 0, 1'b0, 3);
        @(negedge clk);
        idle_bus();
        #1;
        checks++; if (dbg_state !== 2'd0 || req_ready !== 1'b0) begin errors++; $display("FAIL rstmid_state got state=%0d req_ready=%b want 0 0", dbg_state, req_ready); end
        checks++; if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got arvalid=%b rready=%b resp_valid=%b want 0 0 0", axi.arvalid, axi.rready, resp_valid); end
        checks++; if (resp_err !== 1'b0 || resp_line !== 256'h0) begin errors++; $display("FAIL rstmid_data got err=%b line=%h want 0 0", resp_err, resp_line); end
        rst = 1'b0;
        for (int i = 0; i < LW; i++) mdl_line[i] = 32'h0;
        spurious = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) spurious++;
        end
        checks++; if (spurious != 0) begin errors++; $display("FAIL rstmid_old_resp got=%0d want=0", spurious); end
        set_beats_seq(32'h9900, 8);
        model_refill(32'h0000_0040);
        do_refill(32'h0000_0040, 0, 0, 1'b0, -1);
        checks++; if (obs_araddr !== 32'h0000_0040) begin errors++; $display("FAIL rstmid_araddr got=%h want=00000040", obs_araddr); end
        checks++; if (obs_resp_count != 1 || obs_err !== 1'b0) begin errors++; $display("FAIL rstmid_new got resp=%0d err=%b want 1 0", obs_resp_count, obs_err); end
        for (int i = 0; i < LW; i++) begin
            w = exp_q.pop_front();
            checks++; if (obs_line[32*i +: 32] !== w) begin errors++; $display("FAIL rstmid_word%0d got=%h want=%h", i, obs_line[32*i +: 32], w); end
        end
    endtask

`ifdef AXI3_RD_WRAP_EN
    task automatic test_wrap();
        set_beats_seq(32'hB0, 8);
        model_refill(32'h0000_0014);
        do_refill(32'h0000_0014, 0, 0, 1'b0, -1);
        checks++; if (obs_araddr !== 32'h14 || obs_arburst !== 2'b10) begin errors++; $display("FAIL wrap_ar got addr=%h burst=%b want 14 10", obs_araddr, obs_arburst); end
        checks++; if (obs_crit_count != 1 || obs_crit_word !== 32'hB0) begin errors++; $display("FAIL wrap_crit got count=%0d word=%h want 1 b0", obs_crit_count, obs_crit_word); end
        checks++; if (obs_line[191:160] !== 32'hB0 || obs_line[255:224] !== 32'hB2) begin errors++; $display("FAIL wrap_w5w7 got=%h/%h want b0/b2", obs_line[191:160], obs_line[255:224]); end
        checks++; if (obs_line[31:0] !== 32'hB3 || obs_line[159:128] !== 32'hB7) begin errors++; $display("FAIL wrap_w0w4 got=%h/%h want b3/b7", obs_line[31:0], obs_line[159:128]); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL wrap_err got=%b want=0", obs_err); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] w;
        logic [31:0] addr;
        for (int it = 0; it < 10; it++) begin
            addr = $urandom;
            set_beats_seq(32'h0, 10);
            for (int k = 0; k < 10; k++) begin
                bd[k] = $urandom;
                br[k] = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00;
            end
            if ($urandom_range(0, 3) == 0) bl[$urandom_range(0, 6)] = 1'b1;
            model_refill(addr);
            do_refill(addr, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, -1);
            checks++; if (obs_araddr !== exp_araddr(addr)) begin errors++; $display("FAIL rnd%0d_araddr got=%h want=%h", it, obs_araddr, exp_araddr(addr)); end
            checks++; if (obs_resp_count != 1 || obs_beats != exp_beats) begin errors++; $display("FAIL rnd%0d_done got resp=%0d beats=%0d want 1 %0d", it, obs_resp_count, obs_beats, exp_beats); end
            checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL rnd%0d_err got=%b want=%b", it, obs_err, exp_err); end
            checks++; if (obs_crit_count != (WRAP ? 1 : 0) || (WRAP && obs_crit_word !== bd[0])) begin errors++; $display("FAIL rnd%0d_crit got count=%0d word=%h", it, obs_crit_count, obs_crit_word); end
            for (int i = 0; i < LW; i++) begin
                w = exp_q.pop_front();
                checks++; if (obs_line[32*i +: 32] !== w) begin errors++; $display("FAIL rnd%0d_word%0d got=%h want=%h", it, i, obs_line[32*i +: 32], w); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_incr_zero_wait();
        test_ar_backpressure();
        test_bus_error();
        test_len_mismatch();
        test_reset_mid_burst();
`ifdef AXI3_RD_WRAP_EN
        test_wrap();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
